sim_phase_ctrl: RTL and testbench
=================================

SIM_PHASE_CTRL -- requirements
Module: sim_phase_ctrl

Interface
REQ-001 SHALL have parameter CYCLE_WIDTH, default 32, width of all cycle counts.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_valid  input  1  config offer; cfg_ready  output  1  config accept window.
REQ-005 SHALL have ports cfg_warmup, cfg_measure, cfg_drain_limit  input  CYCLE_WIDTH each  phase lengths (drain_limit 0 = unlimited).
REQ-006 SHALL have ports cmd_start, cmd_pause, cmd_resume, cmd_abort  input  1 each  single-cycle commands.
REQ-007 SHALL have port net_empty  input  1  simulated network fully drained.
REQ-008 SHALL have port state  output  3  encoding IDLE=0, CONFIGURED=1, WARMUP=2, MEASURE=3, DRAIN=4, PAUSED=5, COMPLETED=6.
REQ-009 SHALL have ports step_en, stats_en, stats_clear, done, timeout, aborted  output  1 each.
REQ-010 SHALL have ports current_cycle, measured_cycles  output  CYCLE_WIDTH each.

Function
REQ-011 cfg_ready SHALL be high exactly in IDLE, CONFIGURED, COMPLETED; cfg_valid&&cfg_ready latches all three cfg values and next state CONFIGURED.
REQ-012 cmd_start SHALL be honored only in CONFIGURED or COMPLETED: clear current_cycle, measured_cycles, phase counter, done, timeout, aborted; next state WARMUP if latched warmup>0, else MEASURE.
REQ-013 step_en SHALL be high exactly in WARMUP, MEASURE, DRAIN (decoded from registered state, no extra latency); stats_en high exactly in MEASURE.
REQ-014 current_cycle SHALL increment by 1 every cycle step_en is high, saturating at all-ones.
REQ-015 measured_cycles SHALL increment by 1 every cycle in MEASURE, saturating at all-ones.
REQ-016 WARMUP SHALL last exactly cfg_warmup cycles, then MEASURE.
REQ-017 MEASURE SHALL last exactly max(cfg_measure,1) cycles, then DRAIN.
REQ-018 stats_clear SHALL pulse high for the single cycle in which state transitions into MEASURE from a non-PAUSED state.
REQ-019 In DRAIN, net_empty high SHALL move to COMPLETED next cycle; otherwise, with drain_limit>0, after drain_limit DRAIN cycles SHALL move to COMPLETED and set timeout.
REQ-020 net_empty and drain-limit expiry in the same cycle SHALL resolve as net_empty: timeout stays 0.
REQ-021 cmd_pause in WARMUP/MEASURE/DRAIN SHALL enter PAUSED, saving as return state the state that would otherwise have been entered next; all counters frozen while PAUSED.
REQ-022 cmd_resume in PAUSED SHALL return to the saved state without stats_clear; ignored elsewhere.
REQ-023 cmd_abort in WARMUP/MEASURE/DRAIN/PAUSED SHALL move to COMPLETED and set aborted; ignored in IDLE/CONFIGURED/COMPLETED.
REQ-024 Command priority per cycle SHALL be abort > pause > resume > start > cfg accept.
REQ-025 done SHALL be high exactly in COMPLETED; timeout/aborted hold until next start or reset.
REQ-026 Unencoded state values SHALL recover to IDLE next cycle.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, all counters and latched config 0, all 1-bit outputs 0 except cfg_ready (1, decoded from IDLE).
REQ-028 Reset mid-run SHALL abandon the run with no done/aborted indication.

Structure
REQ-029 State encoding and the phase enum SHALL live in shared package sim_pkg, reused by the lifecycle and statistics blocks.
REQ-030 A saturating counter sub-module sat_counter (enable, clear, CYCLE_WIDTH) SHALL implement current_cycle, measured_cycles, and phase counter.

Verification
REQ-031 cfg 3/5/0, start, net_empty high on 2nd DRAIN cycle -> WARMUP 3, MEASURE 5, stats_clear once, DRAIN 2, done, measured_cycles=5, current_cycle=10.
REQ-032 cfg 0/4/3, net_empty low -> start goes straight to MEASURE, DRAIN 3 cycles, COMPLETED with timeout=1.
REQ-033 Pause on last MEASURE cycle, hold 7 cycles, resume -> PAUSED then DRAIN, counters frozen during pause, no stats_clear.
REQ-034 Abort and pause same cycle in MEASURE -> COMPLETED, aborted=1; then start -> reruns latched config, flags cleared.
REQ-035 net_empty and drain expiry coincident -> COMPLETED, timeout=0; CYCLE_WIDTH=4 long run -> current_cycle holds at 15.
REQ-036 reset_n asserted mid-WARMUP, asynchronous to clk -> outputs at reset values immediately, IDLE on release.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared encodings for the simulation phase controller: lifecycle states and
// the measurement phase seen by the statistics side.
package sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CONFIGURED = 3'd1,
        ST_WARMUP     = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_PAUSED     = 3'd5,
        ST_COMPLETED  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        PH_NONE    = 2'd0,
        PH_WARMUP  = 2'd1,
        PH_MEASURE = 2'd2,
        PH_DRAIN   = 2'd3
    } phase_e;

    function automatic phase_e phase_of(input state_e s);
        case (s)
            ST_WARMUP:  return PH_WARMUP;
            ST_MEASURE: return PH_MEASURE;
            ST_DRAIN:   return PH_DRAIN;
            default:    return PH_NONE;
        endcase
    endfunction

    function automatic logic is_cfg_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_CONFIGURED) || (s == ST_COMPLETED);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over enable.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sim_phase_ctrl.sv
// Run lifecycle for a cycle-driven simulation: config latch, warmup/measure/
// drain sequencing, pause/resume/abort, and the cycle statistics counters.
module sim_phase_ctrl
    import sim_pkg::*;
#(
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CYCLE_WIDTH-1:0] cfg_warmup,
    input  logic [CYCLE_WIDTH-1:0] cfg_measure,
    input  logic [CYCLE_WIDTH-1:0] cfg_drain_limit,
    input  logic                   cmd_start,
    input  logic                   cmd_pause,
    input  logic                   cmd_resume,
    input  logic                   cmd_abort,
    input  logic                   net_empty,
    output logic [2:0]             state,
    output logic                   step_en,
    output logic                   stats_en,
    output logic                   stats_clear,
    output logic                   done,
    output logic                   timeout,
    output logic                   aborted,
    output logic [CYCLE_WIDTH-1:0] current_cycle,
    output logic [CYCLE_WIDTH-1:0] measured_cycles
);

    localparam logic [CYCLE_WIDTH-1:0] ONE = CYCLE_WIDTH'(1);

    state_e                 r_state;
    state_e                 r_ret_state;
    state_e                 w_next_state;
    state_e                 w_natural;
    phase_e                 w_phase;
    logic [CYCLE_WIDTH-1:0] r_warmup;
    logic [CYCLE_WIDTH-1:0] r_measure;
    logic [CYCLE_WIDTH-1:0] r_drain_limit;
    logic [CYCLE_WIDTH-1:0] w_phase_cnt;
    logic                   r_timeout;
    logic                   r_aborted;
    logic                   r_stats_clear;
    logic                   w_phase_last;
    logic                   w_drain_expire;
    logic                   w_start;
    logic                   w_cfg_accept;
    logic                   w_pause;
    logic                   w_set_timeout;
    logic                   w_set_aborted;

    assign w_phase   = phase_of(r_state);
    assign step_en   = (w_phase != PH_NONE);
    assign stats_en  = (w_phase == PH_MEASURE);
    assign cfg_ready = is_cfg_state(r_state);

    // Where the active phase would go after this cycle if no command intervened.
    always_comb begin
        w_natural      = r_state;
        w_phase_last   = 1'b0;
        w_drain_expire = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (w_phase_cnt == r_warmup - ONE) begin
                    w_phase_last = 1'b1;
                    w_natural    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if ((r_measure == '0) || (w_phase_cnt == r_measure - ONE)) begin
                    w_phase_last = 1'b1;
                    w_natural    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (net_empty) begin
                    w_phase_last = 1'b1;
                    w_natural    = ST_COMPLETED;
                end else if ((r_drain_limit != '0) && (w_phase_cnt == r_drain_limit - ONE)) begin
                    w_phase_last   = 1'b1;
                    w_drain_expire = 1'b1;
                    w_natural      = ST_COMPLETED;
                end
            end
            default: ;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_start       = 1'b0;
        w_cfg_accept  = 1'b0;
        w_pause       = 1'b0;
        w_set_timeout = 1'b0;
        w_set_aborted = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_cfg_accept = 1'b1;
                    w_next_state = ST_CONFIGURED;
                end
            end
            ST_CONFIGURED, ST_COMPLETED: begin
                if (cmd_start) begin
                    w_start      = 1'b1;
                    w_next_state = (r_warmup != '0) ? ST_WARMUP : ST_MEASURE;
                end else if (cfg_valid) begin
                    w_cfg_accept = 1'b1;
                    w_next_state = ST_CONFIGURED;
                end
            end
            ST_WARMUP, ST_MEASURE, ST_DRAIN: begin
                if (cmd_abort) begin
                    w_set_aborted = 1'b1;
                    w_next_state  = ST_COMPLETED;
                end else begin
                    w_set_timeout = w_drain_expire;
                    if (cmd_pause) begin
                        w_pause      = 1'b1;
                        w_next_state = ST_PAUSED;
                    end else begin
                        w_next_state = w_natural;
                    end
                end
            end
            ST_PAUSED: begin
                if (cmd_abort) begin
                    w_set_aborted = 1'b1;
                    w_next_state  = ST_COMPLETED;
                end else if (cmd_resume) begin
                    w_next_state = r_ret_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_ret_state   <= ST_IDLE;
            r_warmup      <= '0;
            r_measure     <= '0;
            r_drain_limit <= '0;
            r_timeout     <= 1'b0;
            r_aborted     <= 1'b0;
            r_stats_clear <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_stats_clear <= (w_next_state == ST_MEASURE) && (r_state != ST_MEASURE)
                             && (r_state != ST_PAUSED);
            if (w_pause) begin
                r_ret_state <= w_natural;
            end
            if (w_cfg_accept) begin
                r_warmup      <= cfg_warmup;
                r_measure     <= cfg_measure;
                r_drain_limit <= cfg_drain_limit;
            end
            if (w_start) begin
                r_timeout <= 1'b0;
                r_aborted <= 1'b0;
            end else begin
                if (w_set_timeout) r_timeout <= 1'b1;
                if (w_set_aborted) r_aborted <= 1'b1;
            end
        end
    end

    // Phase counter restarts on each phase boundary, so a pause on a last cycle resumes at 0.
    sat_counter #(.WIDTH(CYCLE_WIDTH)) u_phase_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (step_en),
        .i_clr   (w_start || (step_en && w_phase_last)),
        .o_count (w_phase_cnt)
    );

    sat_counter #(.WIDTH(CYCLE_WIDTH)) u_current_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (step_en),
        .i_clr   (w_start),
        .o_count (current_cycle)
    );

    sat_counter #(.WIDTH(CYCLE_WIDTH)) u_measured_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (stats_en),
        .i_clr   (w_start),
        .o_count (measured_cycles)
    );

    assign state       = r_state;
    assign stats_clear = r_stats_clear;
    assign done        = (r_state == ST_COMPLETED);
    assign timeout     = r_timeout;
    assign aborted     = r_aborted;

endmodule

// File: tb/tb_sim_phase_ctrl.sv
// Directed bench for sim_phase_ctrl at CYCLE_WIDTH=4 so saturation is reachable.
module tb_sim_phase_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_warmup;
    logic [CW-1:0] cfg_measure;
    logic [CW-1:0] cfg_drain_limit;
    logic          cmd_start;
    logic          cmd_pause;
    logic          cmd_resume;
    logic          cmd_abort;
    logic          net_empty;
    logic [2:0]    state;
    logic          step_en;
    logic          stats_en;
    logic          stats_clear;
    logic          done;
    logic          timeout;
    logic          aborted;
    logic [CW-1:0] current_cycle;
    logic [CW-1:0] measured_cycles;

    int n_vec = 0;
    int n_err = 0;
    int n_w, n_m, n_d, n_sc;

    sim_phase_ctrl #(.CYCLE_WIDTH(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_warmup      (cfg_warmup),
        .cfg_measure     (cfg_measure),
        .cfg_drain_limit (cfg_drain_limit),
        .cmd_start       (cmd_start),
        .cmd_pause       (cmd_pause),
        .cmd_resume      (cmd_resume),
        .cmd_abort       (cmd_abort),
        .net_empty       (net_empty),
        .state           (state),
        .step_en         (step_en),
        .stats_en        (stats_en),
        .stats_clear     (stats_clear),
        .done            (done),
        .timeout         (timeout),
        .aborted         (aborted),
        .current_cycle   (current_cycle),
        .measured_cycles (measured_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int w, input int m, input int d);
        cfg_valid       = 1'b1;
        cfg_warmup      = CW'(w);
        cfg_measure     = CW'(m);
        cfg_drain_limit = CW'(d);
        tick();
        cfg_valid = 1'b0;
        chk("cfg_state", state, 1);
    endtask

    task automatic start();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Counts cycles per phase until COMPLETED; net_empty is raised on DRAIN cycle empty_at (0 = never).
    task automatic run_phases(input int empty_at, input int budget);
        n_w = 0; n_m = 0; n_d = 0; n_sc = 0;
        for (int i = 0; i < budget; i++) begin
            if (state == 3'd6) break;
            case (state)
                3'd2: n_w++;
                3'd3: n_m++;
                3'd4: n_d++;
                default: ;
            endcase
            if (stats_clear) n_sc++;
            chk("step_en", step_en, (state == 3'd2 || state == 3'd3 || state == 3'd4));
            chk("stats_en", stats_en, (state == 3'd3));
            net_empty = (state == 3'd4) && (n_d == empty_at);
            tick();
        end
        net_empty = 1'b0;
        chk("run_completed", state, 6);
        chk("run_done", done, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_valid = 1'b0; cfg_warmup = '0; cfg_measure = '0; cfg_drain_limit = '0;
        cmd_start = 1'b0; cmd_pause = 1'b0; cmd_resume = 1'b0; cmd_abort = 1'b0;
        net_empty = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_step_en", step_en, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {stats_en, stats_clear, timeout, aborted}, 0);
        chk("rst_counts", {current_cycle, measured_cycles}, 0);
        reset_n = 1'b1;
        tick();

        // Warmup 3, measure 5, drain ended by net_empty on the second DRAIN cycle.
        configure(3, 5, 0);
        start();
        chk("s1_warmup", state, 2);
        chk("s1_cfg_ready", cfg_ready, 0);
        run_phases(2, 40);
        chk("s1_n_warmup", n_w, 3);
        chk("s1_n_measure", n_m, 5);
        chk("s1_n_drain", n_d, 2);
        chk("s1_stats_clear", n_sc, 1);
        chk("s1_measured", measured_cycles, 5);
        chk("s1_current", current_cycle, 10);
        chk("s1_flags", {timeout, aborted}, 0);

        // Ignored commands in COMPLETED.
        cmd_abort = 1'b1; cmd_resume = 1'b1;
        tick();
        cmd_abort = 1'b0; cmd_resume = 1'b0;
        chk("ign_state", state, 6);
        chk("ign_aborted", aborted, 0);

        // No warmup, drain limit 3 expires.
        configure(0, 4, 3);
        start();
        chk("s2_measure_first", state, 3);
        chk("s2_stats_clear", stats_clear, 1);
        run_phases(0, 40);
        chk("s2_n_warmup", n_w, 0);
        chk("s2_n_measure", n_m, 4);
        chk("s2_n_drain", n_d, 3);
        chk("s2_timeout", timeout, 1);
        chk("s2_current", current_cycle, 7);
        chk("s2_measured", measured_cycles, 4);

        // Pause on the last MEASURE cycle, hold, resume into DRAIN.
        configure(2, 3, 0);
        start();
        chk("s3_timeout_cleared", timeout, 0);
        tick(); tick();
        chk("s3_measure", state, 3);
        chk("s3_stats_clear", stats_clear, 1);
        tick(); tick();
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        chk("s3_paused", state, 5);
        for (int i = 0; i < 7; i++) begin
            chk("s3_hold_state", state, 5);
            chk("s3_hold_current", current_cycle, 5);
            chk("s3_hold_measured", measured_cycles, 3);
            chk("s3_hold_step", step_en, 0);
            if (i < 6) tick();
        end
        cmd_resume = 1'b1;
        tick();
        cmd_resume = 1'b0;
        chk("s3_resumed", state, 4);
        chk("s3_no_clear", stats_clear, 0);
        net_empty = 1'b1;
        tick();
        net_empty = 1'b0;
        chk("s3_completed", state, 6);
        chk("s3_current", current_cycle, 6);
        chk("s3_measured", measured_cycles, 3);

        // Abort beats pause; restart reruns the latched config.
        start();
        tick(); tick();
        chk("s4_measure", state, 3);
        cmd_abort = 1'b1; cmd_pause = 1'b1;
        tick();
        cmd_abort = 1'b0; cmd_pause = 1'b0;
        chk("s4_state", state, 6);
        chk("s4_aborted", aborted, 1);
        chk("s4_current", current_cycle, 3);
        start();
        chk("s4_rerun", state, 2);
        chk("s4_flags_clear", {done, timeout, aborted}, 0);
        chk("s4_counts_clear", {current_cycle, measured_cycles}, 0);
        run_phases(1, 40);
        chk("s4_n_warmup", n_w, 2);
        chk("s4_n_measure", n_m, 3);
        chk("s4_current_end", current_cycle, 6);

        // net_empty coincides with drain-limit expiry.
        configure(0, 1, 2);
        start();
        run_phases(2, 40);
        chk("s5_n_drain", n_d, 2);
        chk("s5_timeout", timeout, 0);

        // Zero measure length still gives one MEASURE cycle.
        configure(0, 0, 1);
        start();
        run_phases(0, 40);
        chk("s5_min_measure", n_m, 1);
        chk("s5_min_timeout", timeout, 1);

        // Long run saturates the 4-bit counters.
        configure(15, 15, 0);
        start();
        run_phases(3, 100);
        chk("s6_n_warmup", n_w, 15);
        chk("s6_n_measure", n_m, 15);
        chk("s6_current_sat", current_cycle, 15);
        chk("s6_measured", measured_cycles, 15);

        // Asynchronous reset in the middle of WARMUP.
        configure(3, 2, 0);
        start();
        tick();
        chk("s7_warmup", state, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("s7_rst_state", state, 0);
        chk("s7_rst_cfg_ready", cfg_ready, 1);
        chk("s7_rst_step", step_en, 0);
        chk("s7_rst_current", current_cycle, 0);
        chk("s7_rst_flags", {done, aborted, timeout}, 0);
        #10;
        reset_n = 1'b1;
        tick();
        chk("s7_idle", state, 0);
        chk("s7_no_done", {done, aborted}, 0);
        start();
        chk("s7_start_ignored", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
